// File: rtl/ldpc_layer_addr_gen_if.sv
// Control and status bundle between the load/unload FSM, the layer address generator
// and the RCU array / L- and E-memory consumers.
interface ldpc_layer_addr_gen_if #(
   parameter int P        = 26,
   parameter int ROWWIDTH = 5,
   parameter int LYRWIDTH = 1,
   parameter int ITRWIDTH = 4
);
   logic                loaden;
   logic                start;
   logic                stall;
   logic [ITRWIDTH-1:0] max_itr;
   logic                syn_ok;
   logic                SISOready;
   logic                busy;
   logic                firstprocessing_indicate;
   logic [LYRWIDTH-1:0] LYRindex;
   logic [ROWWIDTH-1:0] rowaddress;
   logic                rd_L;
   logic [P-1:0]        rd_E;
   logic [P-1:0]        rcu_en;
   logic [ITRWIDTH-1:0] itr_used;

   modport master (
      output loaden, start, stall, max_itr, syn_ok,
      input  SISOready, busy, firstprocessing_indicate, LYRindex, rowaddress,
             rd_L, rd_E, rcu_en, itr_used
   );

   modport slave (
      input  loaden, start, stall, max_itr, syn_ok,
      output SISOready, busy, firstprocessing_indicate, LYRindex, rowaddress,
             rd_L, rd_E, rcu_en, itr_used
   );
endinterface

// File: rtl/ldpc_layer_addr_gen.sv
// Layered QC-LDPC address generator: NLAYERS x (ROWDEPTH reads + PIPESTAGES drain) per iteration.
// Optional EARLY_TERM_EN macro ends the decode on syn_ok at the end of the last layer.
module ldpc_layer_addr_gen #(
   parameter int Z              = 511,
   parameter int P              = 26,
   parameter int ROWDEPTH       = 20,
   parameter int P_LAST         = Z - P * (ROWDEPTH - 1),
   parameter int NLAYERS        = 2,
   parameter int PIPESTAGES     = 9,
   parameter int ROWWIDTH       = 5,
   parameter int LYRWIDTH       = 1,
   parameter int PIPECOUNTWIDTH = 4,
   parameter int ITRWIDTH       = 4
) (
   input logic                 clk,
   input logic                 rst,
   ldpc_layer_addr_gen_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PROC  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [ROWWIDTH-1:0]       ROW_LAST  = ROWWIDTH'(ROWDEPTH - 1);
   localparam logic [PIPECOUNTWIDTH-1:0] PC_LAST   = PIPECOUNTWIDTH'(PIPESTAGES - 1);
   localparam logic [LYRWIDTH-1:0]       LYR_LAST  = LYRWIDTH'(NLAYERS - 1);
   localparam logic [P-1:0]              LAST_MASK = {P{1'b1}} >> (P - P_LAST);

   logic [1:0]                state_q, state_d;
   logic [ROWWIDTH-1:0]       row_q, row_d;
   logic [LYRWIDTH-1:0]       layer_q, layer_d;
   logic [ITRWIDTH-1:0]       itr_q, itr_d;
   logic [ITRWIDTH-1:0]       itr_limit_q, itr_limit_d;
   logic [ITRWIDTH-1:0]       itr_used_q, itr_used_d;
   logic [PIPECOUNTWIDTH-1:0] pipecount_q, pipecount_d;
   logic                      rd_q, rd_d;
   logic                      siso_ready_q, siso_ready_d;

   logic                      illegal;
   logic                      more_itr;
   logic                      rd_act;
   logic [P-1:0]              rcu_en;

`ifdef EARLY_TERM_EN
   assign more_itr = (itr_q < itr_limit_q - ITRWIDTH'(1)) && !bus.syn_ok;
`else
   assign more_itr = itr_q < itr_limit_q - ITRWIDTH'(1);
   wire   unused_syn_ok = bus.syn_ok;
`endif

   assign illegal = !(state_q inside {S_IDLE, S_PROC, S_DRAIN});

   always_comb begin
      // NOTE: every _d starts as its _q so no branch can leave a value unassigned (no latches).
      state_d      = state_q;
      row_d        = row_q;
      layer_d      = layer_q;
      itr_d        = itr_q;
      itr_limit_d  = itr_limit_q;
      itr_used_d   = itr_used_q;
      pipecount_d  = pipecount_q;
      rd_d         = rd_q;
      siso_ready_d = siso_ready_q;

      if (bus.loaden || illegal) begin
         state_d      = S_IDLE;
         row_d        = '0;
         layer_d      = '0;
         itr_d        = '0;
         itr_used_d   = '0;
         pipecount_d  = '0;
         rd_d         = 1'b0;
         siso_ready_d = 1'b0;
      end else if (!bus.stall) begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_d      = S_PROC;
                  row_d        = '0;
                  layer_d      = '0;
                  itr_d        = '0;
                  rd_d         = 1'b1;
                  siso_ready_d = 1'b0;
                  itr_limit_d  = (bus.max_itr == '0) ? ITRWIDTH'(1) : bus.max_itr;
               end
            end
            S_PROC: begin
               if (row_q == ROW_LAST) begin
                  state_d     = S_DRAIN;
                  rd_d        = 1'b0;
                  pipecount_d = '0;
               end else begin
                  row_d = row_q + ROWWIDTH'(1);
               end
            end
            S_DRAIN: begin
               // Row stays parked on the last address while the RCU pipeline empties.
               if (pipecount_q != PC_LAST) begin
                  pipecount_d = pipecount_q + PIPECOUNTWIDTH'(1);
               end else if (layer_q < LYR_LAST) begin
                  state_d = S_PROC;
                  layer_d = layer_q + LYRWIDTH'(1);
                  row_d   = '0;
                  rd_d    = 1'b1;
               end else if (more_itr) begin
                  state_d = S_PROC;
                  layer_d = '0;
                  itr_d   = itr_q + ITRWIDTH'(1);
                  row_d   = '0;
                  rd_d    = 1'b1;
               end else begin
                  state_d      = S_IDLE;
                  siso_ready_d = 1'b1;
                  itr_used_d   = itr_q + ITRWIDTH'(1);
                  layer_d      = '0;
                  row_d        = '0;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: reset is synchronous (sampled only on the edge); state updates use <= so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         row_q        <= '0;
         layer_q      <= '0;
         itr_q        <= '0;
         itr_limit_q  <= ITRWIDTH'(1);
         itr_used_q   <= '0;
         pipecount_q  <= '0;
         rd_q         <= 1'b0;
         siso_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         layer_q      <= layer_d;
         itr_q        <= itr_d;
         itr_limit_q  <= itr_limit_d;
         itr_used_q   <= itr_used_d;
         pipecount_q  <= pipecount_d;
         rd_q         <= rd_d;
         siso_ready_q <= siso_ready_d;
      end
   end

   // The last address of a layer only carries P_LAST valid rows; E-memory is empty in iteration 0.
   assign rd_act = rd_q & ~bus.stall;
   assign rcu_en = !rd_act ? '0 : ((row_q == ROW_LAST) ? LAST_MASK : '1);

   assign bus.rd_L                     = rd_act;
   assign bus.rcu_en                   = rcu_en;
   assign bus.rd_E                     = (itr_q == '0) ? '0 : rcu_en;
   assign bus.busy                     = state_q != S_IDLE;
   assign bus.firstprocessing_indicate = (state_q != S_IDLE) && (itr_q == '0) && (layer_q == '0);
   assign bus.LYRindex                 = layer_q;
   assign bus.rowaddress               = row_q;
   assign bus.SISOready                = siso_ready_q;
   assign bus.itr_used                 = itr_used_q;
endmodule

// File: tb/tb_ldpc_layer_addr_gen.sv
// Bench for ldpc_layer_addr_gen: directed timing scenarios plus random traffic against an
// elapsed-cycle reference model (decode position derived by division, not by state tracking).
module tb_ldpc_layer_addr_gen;
   localparam int Z              = 511;
   localparam int P              = 26;
   localparam int ROWDEPTH       = 20;
   localparam int P_LAST         = Z - P * (ROWDEPTH - 1);
   localparam int NLAYERS        = 2;
   localparam int PIPESTAGES     = 9;
   localparam int ROWWIDTH       = 5;
   localparam int LYRWIDTH       = 1;
   localparam int PIPECOUNTWIDTH = 4;
   localparam int ITRWIDTH       = 4;
   localparam int PERIOD         = ROWDEPTH + PIPESTAGES;
   localparam int IPER           = NLAYERS * PERIOD;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ldpc_layer_addr_gen_if #(.P(P), .ROWWIDTH(ROWWIDTH), .LYRWIDTH(LYRWIDTH), .ITRWIDTH(ITRWIDTH)) bus ();

   ldpc_layer_addr_gen #(
      .Z(Z), .P(P), .ROWDEPTH(ROWDEPTH), .P_LAST(P_LAST), .NLAYERS(NLAYERS),
      .PIPESTAGES(PIPESTAGES), .ROWWIDTH(ROWWIDTH), .LYRWIDTH(LYRWIDTH),
      .PIPECOUNTWIDTH(PIPECOUNTWIDTH), .ITRWIDTH(ITRWIDTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: a decode is just a count of unstalled cycles since start.
   bit m_active, m_siso, chk_en;
   int m_t, m_total, m_limit, m_itr_used;

   always @(posedge clk) begin
      bit done;
      if (!rst || bus.loaden) begin
         m_active   = 0;
         m_siso     = 0;
         m_t        = 0;
         m_itr_used = 0;
         if (!rst) chk_en = 1;
      end else if (!bus.stall) begin
         if (!m_active) begin
            if (bus.start) begin
               m_active = 1;
               m_t      = 0;
               m_limit  = (bus.max_itr == 0) ? 1 : int'(bus.max_itr);
               m_total  = m_limit * IPER;
               m_siso   = 0;
            end
         end else begin
            done = (m_t == m_total - 1);
`ifdef EARLY_TERM_EN
            if (bus.syn_ok && (m_t % IPER) == IPER - 1) done = 1;
`endif
            if (done) begin
               m_active   = 0;
               m_siso     = 1;
               m_itr_used = m_t / IPER + 1;
            end else begin
               m_t++;
            end
         end
      end
   end

   always @(negedge clk) begin
      int itr, lay, off, row;
      bit rd, rdl;
      logic [P-1:0] rcu, rde;
      if (chk_en) begin
         itr = 0; lay = 0; row = 0; rd = 0;
         if (m_active) begin
            itr = m_t / IPER;
            lay = (m_t / PERIOD) % NLAYERS;
            off = m_t % PERIOD;
            rd  = off < ROWDEPTH;
            row = rd ? off : ROWDEPTH - 1;
         end
         rdl = rd && !bus.stall;
         for (int i = 0; i < P; i++)
            rcu[i] = rdl && (i < ((row == ROWDEPTH - 1) ? P_LAST : P));
         rde = (itr == 0) ? '0 : rcu;
         check("busy", bus.busy, m_active);
         check("siso_ready", bus.SISOready, m_siso);
         check("rowaddress", bus.rowaddress, row);
         check("lyrindex", bus.LYRindex, lay);
         check("rd_l", bus.rd_L, rdl);
         check("rcu_en", bus.rcu_en, rcu);
         check("rd_e", bus.rd_E, rde);
         check("first_ind", bus.firstprocessing_indicate, m_active && itr == 0 && lay == 0);
         check("itr_used", bus.itr_used, m_itr_used);
      end
   end

   // One decode; j counts cycles after the start edge. Returns the cycle SISOready is first seen
   // (or the cycle after a loaden abort).
   task automatic run(input string name, input int m, input int stall_at, input int loaden_at,
                      input int syn_at, input bit detail, output int end_j);
      end_j = -1;
      @(posedge clk); #1;
      bus.start   = 1'b1;
      bus.max_itr = ITRWIDTH'(m);
      for (int j = 1; j <= 800 && end_j < 0; j++) begin
         @(posedge clk); #1;
         bus.start  = (j == 50);
         bus.stall  = (stall_at > 0) && (j >= stall_at) && (j < stall_at + 3);
         bus.loaden = (j == loaden_at);
         bus.syn_ok = (j == syn_at);
         @(negedge clk);
         if (bus.SISOready) end_j = j;
         if (detail) begin
            if (j == 1)  check({name, "_rdl_k1"}, bus.rd_L, 1);
            if (j == 1)  check({name, "_first_k1"}, bus.firstprocessing_indicate, 1);
            if (j == 20) check({name, "_rdl_k20"}, bus.rd_L, 1);
            if (j == 20) check({name, "_rcu_row19_itr0"}, bus.rcu_en, 26'h001FFFF);
            if (j == 20) check({name, "_rde_itr0"}, bus.rd_E, 0);
            if (j == 21) check({name, "_rdl_k21"}, bus.rd_L, 0);
            if (j == 29) check({name, "_rdl_k29"}, bus.rd_L, 0);
            if (j == 29) check({name, "_first_k29"}, bus.firstprocessing_indicate, 1);
            if (j == 30) check({name, "_lyr_k30"}, bus.LYRindex, 1);
            if (j == 30) check({name, "_first_k30"}, bus.firstprocessing_indicate, 0);
            if (j == 64) check({name, "_rde_row5"}, bus.rd_E, 26'h3FFFFFF);
            if (j == 78) check({name, "_rcu_row19"}, bus.rcu_en, 26'h001FFFF);
            if (j == 78) check({name, "_rde_row19"}, bus.rd_E, 26'h001FFFF);
         end
         if (stall_at > 0 && j == stall_at) check({name, "_rdl_stalled"}, bus.rd_L, 0);
         if (stall_at > 0 && j == stall_at + 3) check({name, "_row_held"}, bus.rowaddress, stall_at - 1);
         if (loaden_at > 0 && j == loaden_at + 1) begin
            check({name, "_busy"}, bus.busy, 0);
            check({name, "_rdl"}, bus.rd_L, 0);
            check({name, "_siso"}, bus.SISOready, 0);
            check({name, "_row"}, bus.rowaddress, 0);
            end_j = j;
         end
      end
      if (end_j < 0) check({name, "_timeout"}, 0, 1);
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.stall  = 1'b0;
      bus.loaden = 1'b0;
      bus.syn_ok = 1'b0;
   endtask

   initial begin
      int e;
      bus.start = 0; bus.stall = 0; bus.loaden = 0; bus.syn_ok = 0; bus.max_itr = '0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_siso", bus.SISOready, 0);
      check("rst_row", bus.rowaddress, 0);
      check("rst_itr_used", bus.itr_used, 0);

      run("itr10", 10, 0, 0, 0, 1, e);
      check("itr10_latency", e, 581);
      check("itr10_used", bus.itr_used, 10);

      run("itr0", 0, 0, 0, 0, 0, e);
      check("itr0_latency", e, 59);
      check("itr0_used", bus.itr_used, 1);

      run("stall", 10, 10, 0, 0, 0, e);
      check("stall_latency", e, 584);

      run("loaden", 10, 0, 100, 0, 0, e);
      check("loaden_abort_cycle", e, 101);

      run("restart", 1, 0, 0, 0, 0, e);
      check("restart_latency", e, 59);
      check("restart_used", bus.itr_used, 1);

      run("early", 10, 0, 0, 174, 0, e);
`ifdef EARLY_TERM_EN
      check("early_latency", e, 175);
      check("early_used", bus.itr_used, 3);
`else
      check("early_latency", e, 581);
      check("early_used", bus.itr_used, 10);
`endif

      for (int c = 0; c < 5000; c++) begin
         @(posedge clk); #1;
         rst         = ($urandom % 2000) != 0;
         bus.start   = ($urandom % 6) == 0;
         bus.max_itr = ITRWIDTH'($urandom % 4);
         bus.stall   = ($urandom % 12) == 0;
         bus.loaden  = ($urandom % 400) == 0;
         bus.syn_ok  = ($urandom % 5) == 0;
      end
      @(posedge clk); #1;
      rst = 1'b1; bus.start = 0; bus.stall = 0; bus.loaden = 0; bus.syn_ok = 0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
